counter_mod_ud: RTL and testbench

COUNTER_MOD_UD -- requirements
Module: counter_mod_ud

---
 rtl/counter_mod_ud.sv | 87 ++++++++
 tb/tb_counter_mod_ud.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod_ud.sv
// Modulo-L up/down counter with load, run-time modulus register and
// terminal-count flag for cascading; wraps or saturates at the ends.
module counter_mod_ud #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned ULIMIT   = 10,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             i_sclr,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_ld,
   input  logic [WIDTH-1:0] i_ld_val,
   input  logic             i_lim_wr,
   input  logic [WIDTH-1:0] i_lim,
   output logic [WIDTH-1:0] o_cnt,
   output logic [WIDTH-1:0] o_lim,
   output logic             o_tc,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] LIM_RST = WIDTH'(ULIMIT);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic [WIDTH-1:0] top;
   logic             wrap_q, wrap_d;
   logic             at_top, at_zero;

   // Compare with one extra bit so L of 0 or 1 never underflows T.
   always_comb begin
      top = '0;
      if ({1'b0, lim_q} >= (WIDTH+1)'(2)) begin
         top = lim_q - WIDTH'(1);
      end
   end

   assign at_top  = (cnt_q >= top);
   assign at_zero = (cnt_q == '0);
   assign wrap_d  = i_en & ~i_ld & ~i_sclr &
                    ((i_up & at_top) | (~i_up & at_zero));

   always_comb begin
      cnt_d = cnt_q;
      lim_d = lim_q;
      if (i_lim_wr) begin
         lim_d = i_lim;
      end
      if (i_ld) begin
         cnt_d = (i_ld_val <= top) ? i_ld_val : top;
      end else if (i_en) begin
         if (i_up) begin
            if (at_top) begin
               cnt_d = SATURATE ? top : '0;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               cnt_d = SATURATE ? '0 : top;
            end else if (cnt_q > top) begin
               cnt_d = top;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_sclr) begin
         cnt_q  <= '0;
         lim_q  <= LIM_RST;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lim_q  <= lim_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_cnt  = cnt_q;
   assign o_lim  = lim_q;
   assign o_tc   = wrap_d;
   assign o_wrap = wrap_q;

endmodule

// File: tb/tb_counter_mod_ud.sv
// Directed self-checking bench for counter_mod_ud: wrap and saturate
// instances sharing stimulus, plus a two-stage decimal cascade.
module tb_counter_mod_ud;

   logic       clk = 1'b0;
   logic       sclr = 1'b0, en = 1'b0, up = 1'b0, ld = 1'b0, lim_wr = 1'b0;
   logic [3:0] ld_val = '0, lim = '0;
   logic [3:0] cnt, lim_o, cnt_s, lim_s;
   logic       tc, wrap, tc_s, wrap_s;

   logic       c_sclr = 1'b0, c_en = 1'b0;
   logic [3:0] lo_cnt, lo_lim, hi_cnt, hi_lim;
   logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   counter_mod_ud #(.WIDTH(4), .ULIMIT(10), .SATURATE(1'b0)) dut (
      .clk(clk), .i_sclr(sclr), .i_en(en), .i_up(up), .i_ld(ld),
      .i_ld_val(ld_val), .i_lim_wr(lim_wr), .i_lim(lim),
      .o_cnt(cnt), .o_lim(lim_o), .o_tc(tc), .o_wrap(wrap));

   counter_mod_ud #(.WIDTH(4), .ULIMIT(10), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .i_sclr(sclr), .i_en(en), .i_up(up), .i_ld(ld),
      .i_ld_val(ld_val), .i_lim_wr(lim_wr), .i_lim(lim),
      .o_cnt(cnt_s), .o_lim(lim_s), .o_tc(tc_s), .o_wrap(wrap_s));

   counter_mod_ud #(.WIDTH(4), .ULIMIT(10), .SATURATE(1'b0)) casc_lo (
      .clk(clk), .i_sclr(c_sclr), .i_en(c_en), .i_up(1'b1), .i_ld(1'b0),
      .i_ld_val(4'd0), .i_lim_wr(1'b0), .i_lim(4'd0),
      .o_cnt(lo_cnt), .o_lim(lo_lim), .o_tc(lo_tc), .o_wrap(lo_wrap));

   counter_mod_ud #(.WIDTH(4), .ULIMIT(10), .SATURATE(1'b0)) casc_hi (
      .clk(clk), .i_sclr(c_sclr), .i_en(lo_tc), .i_up(1'b1), .i_ld(1'b0),
      .i_ld_val(4'd0), .i_lim_wr(1'b0), .i_lim(4'd0),
      .o_cnt(hi_cnt), .o_lim(hi_lim), .o_tc(hi_tc), .o_wrap(hi_wrap));

   // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sclr = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; lim_wr = 1'b0;
      ld_val = '0; lim = '0;
      tick();
      sclr = 1'b0;
   endtask

   task automatic test_reset();
      sclr = 1'b1; en = 1'b1; up = 1'b1; ld = 1'b1; ld_val = 4'd5;
      lim_wr = 1'b1; lim = 4'd3;
      @(negedge clk);
      n_checks++;
      if (tc !== 1'b0) begin
         n_fail++; $display("FAIL reset_tc: got %b want 0", tc);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd0 || lim_o !== 4'd10 || wrap !== 1'b0 || tc !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: cnt=%0d lim=%0d wrap=%b tc=%b want 0/10/0/0",
                  cnt, lim_o, wrap, tc);
      end
      n_checks++;
      if (cnt_s !== 4'd0 || lim_s !== 4'd10 || wrap_s !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state_sat: cnt=%0d lim=%0d wrap=%b want 0/10/0",
                  cnt_s, lim_s, wrap_s);
      end
      tick();
      sclr = 1'b0; ld = 1'b0; lim_wr = 1'b0; en = 1'b0;
   endtask

   task automatic test_up_count();
      do_reset();
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_checks++;
         if (cnt !== 4'(i % 10) || tc !== (i == 9) || wrap !== (i == 10)) begin
            n_fail++;
            $display("FAIL up_count[%0d]: cnt=%0d tc=%b wrap=%b want %0d/%b/%b",
                     i, cnt, tc, wrap, i % 10, (i == 9), (i == 10));
         end
         n_checks++;
         if (cnt_s !== 4'((i < 9) ? i : 9) || tc_s !== (i >= 9) || wrap_s !== (i >= 10)) begin
            n_fail++;
            $display("FAIL up_sat[%0d]: cnt=%0d tc=%b wrap=%b want %0d/%b/%b",
                     i, cnt_s, tc_s, wrap_s, (i < 9) ? i : 9, (i >= 9), (i >= 10));
         end
         tick();
      end
   endtask

   task automatic test_down_count();
      do_reset();
      en = 1'b1; up = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_checks++;
         if (cnt !== 4'((10 - i + 10) % 10) || tc !== (((10 - i + 10) % 10) == 0) ||
             wrap !== (i == 1 || i == 11)) begin
            n_fail++;
            $display("FAIL down_count[%0d]: cnt=%0d tc=%b wrap=%b want %0d/%b/%b",
                     i, cnt, tc, wrap, (10 - i + 10) % 10,
                     (((10 - i + 10) % 10) == 0), (i == 1 || i == 11));
         end
         n_checks++;
         if (cnt_s !== 4'd0 || tc_s !== 1'b1 || wrap_s !== (i >= 1)) begin
            n_fail++;
            $display("FAIL down_sat[%0d]: cnt=%0d tc=%b wrap=%b want 0/1/%b",
                     i, cnt_s, tc_s, wrap_s, (i >= 1));
         end
         tick();
      end
   endtask

   task automatic test_load();
      do_reset();
      en = 1'b1; up = 1'b1; ld = 1'b1; ld_val = 4'd15;
      @(negedge clk);
      n_checks++;
      if (tc !== 1'b0) begin
         n_fail++; $display("FAIL load_tc: got %b want 0", tc);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd9 || cnt_s !== 4'd9) begin
         n_fail++; $display("FAIL load_clamp: cnt=%0d sat=%0d want 9", cnt, cnt_s);
      end
      n_checks++;
      if (tc !== 1'b0) begin
         n_fail++; $display("FAIL load_tc_at_top: got %b want 0", tc);
      end
      ld_val = 4'd3;
      tick();
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd3 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL load_val: cnt=%0d wrap=%b want 3/0", cnt, wrap);
      end
      ld = 1'b0; en = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd3 || tc !== 1'b0) begin
         n_fail++; $display("FAIL hold: cnt=%0d tc=%b want 3/0", cnt, tc);
      end
   endtask

   task automatic test_lim_write();
      do_reset();
      ld = 1'b1; ld_val = 4'd8;
      tick();
      ld = 1'b0; lim_wr = 1'b1; lim = 4'd5; en = 1'b1; up = 1'b1;
      @(negedge clk);
      n_checks++;
      if (tc !== 1'b0) begin
         n_fail++; $display("FAIL limwr_tc: got %b want 0", tc);
      end
      tick();
      lim_wr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd9 || lim_o !== 4'd5 || cnt_s !== 4'd9) begin
         n_fail++;
         $display("FAIL limwr_old_l: cnt=%0d lim=%0d sat=%0d want 9/5/9", cnt, lim_o, cnt_s);
      end
      n_checks++;
      if (tc !== 1'b1 || tc_s !== 1'b1) begin
         n_fail++; $display("FAIL limwr_tc_out_of_range: tc=%b sat=%b want 1/1", tc, tc_s);
      end
      tick();
      en = 1'b0; ld = 1'b1; ld_val = 4'd7;
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd0 || wrap !== 1'b1 || cnt_s !== 4'd4 || wrap_s !== 1'b1) begin
         n_fail++;
         $display("FAIL limwr_wrap: cnt=%0d wrap=%b sat=%0d satwrap=%b want 0/1/4/1",
                  cnt, wrap, cnt_s, wrap_s);
      end
      tick();
      ld = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd4 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL limwr_load_clamp: cnt=%0d wrap=%b want 4/0", cnt, wrap);
      end
   endtask

   task automatic test_small_lim();
      do_reset();
      lim_wr = 1'b1; lim = 4'd1; up = 1'b1;
      tick();
      lim_wr = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (cnt !== 4'd0 || tc !== 1'b1 || wrap !== (i > 0)) begin
            n_fail++;
            $display("FAIL lim1_up[%0d]: cnt=%0d tc=%b wrap=%b want 0/1/%b",
                     i, cnt, tc, wrap, (i > 0));
         end
         tick();
      end
      en = 1'b0;
      @(negedge clk);
      n_checks++;
      if (tc !== 1'b0) begin
         n_fail++; $display("FAIL lim1_idle_tc: got %b want 0", tc);
      end
      tick();
      lim_wr = 1'b1; lim = 4'd0; en = 1'b1; up = 1'b0;
      @(negedge clk);
      n_checks++;
      if (tc !== 1'b1 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL lim1_down: tc=%b wrap=%b want 1/0", tc, wrap);
      end
      tick();
      lim_wr = 1'b0; ld = 1'b1; ld_val = 4'd5;
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd0 || lim_o !== 4'd0 || wrap !== 1'b1 || tc !== 1'b0) begin
         n_fail++;
         $display("FAIL lim0_state: cnt=%0d lim=%0d wrap=%b tc=%b want 0/0/1/0",
                  cnt, lim_o, wrap, tc);
      end
      tick();
      ld = 1'b0; up = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cnt !== 4'd0 || tc !== 1'b1) begin
         n_fail++; $display("FAIL lim0_pinned: cnt=%0d tc=%b want 0/1", cnt, tc);
      end
      tick();
      en = 1'b0;
   endtask

   task automatic test_cascade();
      c_sclr = 1'b1; c_en = 1'b0;
      tick();
      c_sclr = 1'b0; c_en = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk);
         n_checks++;
         if (lo_cnt !== 4'(i % 10) || hi_cnt !== 4'((i / 10) % 10) ||
             lo_wrap !== (i > 0 && i % 10 == 0) || hi_wrap !== (i == 100) ||
             hi_tc !== (i == 99)) begin
            n_fail++;
            $display("FAIL cascade[%0d]: hi=%0d lo=%0d lw=%b hw=%b htc=%b want %0d/%0d/%b/%b/%b",
                     i, hi_cnt, lo_cnt, lo_wrap, hi_wrap, hi_tc, (i / 10) % 10, i % 10,
                     (i > 0 && i % 10 == 0), (i == 100), (i == 99));
         end
         tick();
      end
   endtask

   task automatic test_sclr_midrun();
      // Cascade now reads 01; advance to 39 so the clear lands on a terminal step.
      for (int i = 0; i < 38; i++) tick();
      c_sclr = 1'b1;
      @(negedge clk);
      n_checks++;
      if (lo_cnt !== 4'd9 || hi_cnt !== 4'd3 || lo_tc !== 1'b0) begin
         n_fail++;
         $display("FAIL sclr_pre: hi=%0d lo=%0d lo_tc=%b want 3/9/0", hi_cnt, lo_cnt, lo_tc);
      end
      tick();
      c_sclr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (lo_cnt !== 4'd0 || hi_cnt !== 4'd0 || lo_wrap !== 1'b0 || hi_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL sclr_mid: hi=%0d lo=%0d lw=%b hw=%b want 0/0/0/0",
                  hi_cnt, lo_cnt, lo_wrap, hi_wrap);
      end
      tick();
      c_en = 1'b0;
   endtask

   initial begin
      tick();
      test_reset();
      test_up_count();
      test_down_count();
      test_load();
      test_lim_write();
      test_small_lim();
      test_cascade();
      test_sclr_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
